// File: rtl/param_rr_encoder.sv
// ---------------------------------------------------------------------------------------------
// param_rr_encoder
//
// N-to-log2(N) encoder with a registered output and a valid/ready handshake toward a single
// downstream consumer. Two arbitration modes are available:
//   mode = 0 : fixed priority. The lowest set index of req wins.
//   mode = 1 : round-robin. The scan starts at rr_ptr and wraps circularly at N.
// A multi-hot request is legal. It still produces a grant, and err is raised alongside that
// result so the consumer can tell the request was ambiguous.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   en     in   1  enable for new loads; a held result still drains when en=0
//   mode   in   1  0 = fixed priority, 1 = round-robin
//   req    in   N  request vector, sampled on clk
//   ready  in   1  consumer accepts y/err when valid & ready
//   y      out  W  encoded index of the granted request
//   valid  out  1  y and err hold a result
//   err    out  1  more than one req bit was set when y was loaded
//
// All outputs come straight from flops. req, mode, en and ready only affect next state.
// ---------------------------------------------------------------------------------------------
module param_rr_encoder #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    input  logic                 ready,
    output logic [$clog2(N)-1:0] y,
    output logic                 valid,
    output logic                 err
);

    localparam int unsigned W = $clog2(N);

    // Highest legal index, used for the round-robin wrap (N need not be a power of two).
    localparam logic [W-1:0] LastIdx = W'(N - 1);

    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;

    logic         out_free;
    logic         do_load;
    logic         req_multi;
    logic [W-1:0] sel_fixed;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;

    // The output register can take a new result when it is empty or is being drained now.
    assign out_free = !valid_q || ready;
    assign do_load  = out_free && en && (req != '0);

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign req_multi = (req & (req - N'(1))) != '0;

    // Fixed priority: scan from the top down so the lowest set index is the last one assigned.
    always_comb begin
        sel_fixed = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_fixed = W'(i);
            end
        end
    end

    // Round-robin: the k-th candidate is (rr_ptr + k) mod N. Scan k from the top down so the
    // smallest offset with a set bit wins. rr_ptr < N and k < N, so one subtraction reduces
    // the sum modulo N.
    always_comb begin
        int unsigned idx;
        sel_rr = '0;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                sel_rr = W'(idx);
            end
        end
    end

    assign sel = mode ? sel_rr : sel_fixed;

    always_comb begin
        y_d      = y_q;
        valid_d  = valid_q;
        err_d    = err_q;
        rr_ptr_d = rr_ptr_q;

        if (do_load) begin
            y_d     = sel;
            valid_d = 1'b1;
            err_d   = req_multi;
            // Only round-robin grants move the pointer; fixed-priority grants leave it alone.
            if (mode) begin
                rr_ptr_d = (sel == LastIdx) ? '0 : sel + W'(1);
            end
        end else if (out_free) begin
            // Nothing to load. Drop valid but keep the last y/err for observability.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            y_q      <= y_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_param_rr_encoder.sv
module tb_param_rr_encoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       ready;
    logic [7:0] req;
    logic [4:0] req5;
    logic [2:0] y;
    logic [2:0] y5;
    logic       valid;
    logic       valid5;
    logic       err;
    logic       err5;

    int checks;
    int failures;

    param_rr_encoder #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .req   (req),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .err   (err)
    );

    param_rr_encoder #(.N(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .req   (req5),
        .ready (ready),
        .y     (y5),
        .valid (valid5),
        .err   (err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs are then sampled and re-driven 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        ready    = 1'b1;
        req      = '0;
        req5     = '0;

        // Reset state
        #1;
        check("rst_y", 32'(y), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_err", 32'(err), 0);
        step();
        step();
        rst_n = 1'b1;

        // One-hot sweep in fixed priority
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req = 8'(1 << i);
            step();
            check("sweep_y", 32'(y), 32'(i));
            check("sweep_valid", 32'(valid), 1);
            check("sweep_err", 32'(err), 0);
        end

        // Fixed priority on a multi-hot request, held for two loads
        req = 8'b1010_0100;
        step();
        check("fixed_y", 32'(y), 2);
        check("fixed_err", 32'(err), 1);
        step();
        check("fixed_y_hold", 32'(y), 2);
        check("fixed_err_hold", 32'(err), 1);

        // Round-robin with every request set; rr_ptr is still 0 after the fixed-mode loads
        mode = 1'b1;
        req  = 8'hFF;
        req5 = 5'h1F;
        for (int i = 0; i < 9; i++) begin
            step();
            check("rr8_y", 32'(y), 32'(i % 8));
            check("rr8_err", 32'(err), 1);
            check("rr5_y", 32'(y5), 32'(i % 5));
            check("rr5_valid", 32'(valid5), 1);
        end
        req5 = '0;
        // Last rr8 grant was 0, so rr_ptr = 1 from here on.

        // Backpressure: load y=3, then stall while req changes
        mode = 1'b0;
        req  = 8'h08;
        step();
        check("bp_load_y", 32'(y), 3);
        ready = 1'b0;
        req   = 8'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_y", 32'(y), 3);
            check("bp_hold_valid", 32'(valid), 1);
        end
        ready = 1'b1;
        step();
        check("bp_release_y", 32'(y), 7);
        check("bp_release_valid", 32'(valid), 1);
        check("bp_release_err", 32'(err), 0);

        // en=0 with ready drains valid; y keeps its last value
        en = 1'b0;
        step();
        check("en0_valid", 32'(valid), 0);
        check("en0_y_kept", 32'(y), 7);

        // req=0 with ready drains valid
        en  = 1'b1;
        req = 8'h10;
        step();
        check("empty_load_y", 32'(y), 4);
        req = 8'h00;
        step();
        check("empty_valid", 32'(valid), 0);
        check("empty_y_kept", 32'(y), 4);

        // A load into an empty register happens even with ready=0; en=0 then waits for ready
        req   = 8'h02;
        ready = 1'b0;
        step();
        check("stall_load_y", 32'(y), 1);
        check("stall_load_valid", 32'(valid), 1);
        en = 1'b0;
        step();
        step();
        check("en0_stall_valid", 32'(valid), 1);
        check("en0_stall_y", 32'(y), 1);
        ready = 1'b1;
        step();
        check("en0_drain_valid", 32'(valid), 0);

        // rr_ptr (=1) survived the fixed-mode traffic
        en   = 1'b1;
        mode = 1'b1;
        req  = 8'hFF;
        step();
        check("rr_retain_y", 32'(y), 1);
        // rr_ptr = 2; scanning 2..7 finds nothing, wraps to 0
        req = 8'b0000_0011;
        step();
        check("rr_wrap_y", 32'(y), 0);
        check("rr_wrap_err", 32'(err), 1);
        step();
        check("rr_next_y", 32'(y), 1);

        // Asynchronous reset mid-cycle with a pending result
        ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_y", 32'(y), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        req   = 8'hFF;
        step();
        check("postrst_rr_y", 32'(y), 0);
        check("postrst_valid", 32'(valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
